// File: rtl/apb_bridge_pkg.sv
// apb_bridge_pkg
//   Shared definitions for the AHB-Lite to APB3 bridge: FSM state encoding,
//   AHB HTRANS / HRESP codes and a helper that sizes the slot-select field.
//   No ports (package).
package apb_bridge_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LATCH  = 3'd1,
      S_SETUP  = 3'd2,
      S_ACCESS = 3'd3,
      S_DONE   = 3'd4,
      S_ERR1   = 3'd5,
      S_ERR2   = 3'd6
   } state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   // Width of the HADDR slot field; a single-slot bridge still carries one bit.
   function automatic int slot_width(input int nslots);
      return (nslots > 1) ? $clog2(nslots) : 1;
   endfunction

   // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY are answered OKAY.
   function automatic logic is_active(input logic [1:0] htrans);
      return !((htrans == HTRANS_IDLE) || (htrans == HTRANS_BUSY));
   endfunction

endpackage

// File: rtl/apb_bridge_decode.sv
// apb_bridge_decode
//   Turns the slot index taken from HADDR into a one-hot PSEL pattern and
//   flags indices that have no slave behind them.
//   Ports:
//     slot          in  SLOT_W  slot index from the address
//     onehot        out NSLOTS  one-hot select (all zero when out of range)
//     out_of_range  out 1       index >= NSLOTS (never set when NSLOTS == 1)
module apb_bridge_decode #(
   parameter int NSLOTS = 16,
   parameter int SLOT_W = 4
) (
   input  logic [SLOT_W-1:0] slot,
   output logic [NSLOTS-1:0] onehot,
   output logic              out_of_range
);

   always_comb begin
      onehot       = '0;
      out_of_range = 1'b0;
      if (NSLOTS == 1) begin
         // A single slave answers every address; the slot bits are ignored.
         onehot[0] = 1'b1;
      end else begin
         if (int'(slot) >= NSLOTS) out_of_range = 1'b1;
         for (int i = 0; i < NSLOTS; i++) begin
            if (slot == SLOT_W'(i)) onehot[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/apb_bridge_multi.sv
// apb_bridge_multi
//   AHB-Lite slave to APB3 master bridge with NSLOTS slave selects decoded
//   from HADDR[SLOT_LSB +: slot_width], and an optional ACCESS timeout.
//   Ports:
//     HCLK, HRESETN                         clock, async active-low reset
//     HSEL/HADDR/HWRITE/HTRANS/HWDATA/HREADYIN   AHB-Lite slave inputs
//     HREADYOUT/HRESP/HRDATA                AHB-Lite slave outputs
//     PSEL/PADDR/PWRITE/PENABLE/PWDATA      APB3 master outputs
//     PRDATA/PREADY/PSLVERR                 APB3 master inputs
//     TOUT                                  one-cycle pulse on timeout abort
//     dbg_state                             current FSM state
//
//   Handshake: an AHB transfer is taken on an edge where HSEL & HREADYIN &
//   HTRANS is NONSEQ/SEQ while the bridge is IDLE, DONE or ERR2; the data
//   phase is stretched with HREADYOUT=0 until the APB side finishes. An APB
//   beat completes on the edge where PSEL & PENABLE & PREADY are all high.
module apb_bridge_multi
   import apb_bridge_pkg::*;
#(
   parameter int NSLOTS   = 16,
   parameter int SLOT_LSB = 24,
   parameter int ADDR_W   = 32,
   parameter int TIMEOUT  = 256
) (
   input  logic              HCLK,
   input  logic              HRESETN,
   input  logic              HSEL,
   input  logic [31:0]       HADDR,
   input  logic              HWRITE,
   input  logic [1:0]        HTRANS,
   input  logic [31:0]       HWDATA,
   input  logic              HREADYIN,
   output logic              HREADYOUT,
   output logic              HRESP,
   output logic [31:0]       HRDATA,
   output logic [NSLOTS-1:0] PSEL,
   output logic [ADDR_W-1:0] PADDR,
   output logic              PWRITE,
   output logic              PENABLE,
   output logic [31:0]       PWDATA,
   input  logic [31:0]       PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR,
   output logic              TOUT,
   output state_t            dbg_state
);

   localparam int SLOT_W = slot_width(NSLOTS);
   localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);

   state_t              state;
   logic [ADDR_W-1:0]   addr_q;
   logic                write_q;
   logic [NSLOTS-1:0]   sel_q;
   logic                oor_q;
   logic [CNT_W-1:0]    to_cnt;
   logic [CNT_W-1:0]    cnt_next;
   logic [NSLOTS-1:0]   dec_sel;
   logic                dec_oor;
   logic                accept;
   logic                timeout_hit;
   logic                unused_ok;

   apb_bridge_decode #(
      .NSLOTS (NSLOTS),
      .SLOT_W (SLOT_W)
   ) u_decode (
      .slot         (HADDR[SLOT_LSB +: SLOT_W]),
      .onehot       (dec_sel),
      .out_of_range (dec_oor)
   );

   assign accept = (state inside {S_IDLE, S_DONE, S_ERR2}) && HSEL && HREADYIN
                   && is_active(HTRANS);

   // Abort on the wait cycle that would make the counter reach TIMEOUT, so
   // the slave sees exactly TIMEOUT ACCESS cycles; PREADY in that same cycle
   // still wins because it is checked first.
   assign cnt_next    = to_cnt + CNT_W'(1);
   assign timeout_hit = (TIMEOUT > 0) && (cnt_next == TO_LIMIT);

   assign dbg_state = state;
   assign unused_ok = ^HADDR;

   always_ff @(posedge HCLK or negedge HRESETN) begin
      if (!HRESETN) begin
         state     <= S_IDLE;
         HREADYOUT <= 1'b1;
         HRESP     <= HRESP_OKAY;
         HRDATA    <= '0;
         PSEL      <= '0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PADDR     <= '0;
         PWDATA    <= '0;
         TOUT      <= 1'b0;
         to_cnt    <= '0;
         addr_q    <= '0;
         write_q   <= 1'b0;
         sel_q     <= '0;
         oor_q     <= 1'b0;
      end else begin
         TOUT <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERR2: begin
               if (accept) begin
                  state     <= S_LATCH;
                  HREADYOUT <= 1'b0;
                  HRESP     <= HRESP_OKAY;
                  addr_q    <= HADDR[ADDR_W-1:0];
                  write_q   <= HWRITE;
                  sel_q     <= dec_sel;
                  oor_q     <= dec_oor;
               end else begin
                  state     <= S_IDLE;
                  HREADYOUT <= 1'b1;
                  HRESP     <= HRESP_OKAY;
               end
            end
            S_LATCH: begin
               // HWDATA is valid only in the AHB data phase, i.e. now.
               PWDATA <= HWDATA;
               if (oor_q) begin
                  state <= S_ERR1;
                  HRESP <= HRESP_ERROR;
               end else begin
                  state   <= S_SETUP;
                  PSEL    <= sel_q;
                  PENABLE <= 1'b0;
                  PADDR   <= addr_q;
                  PWRITE  <= write_q;
               end
            end
            S_SETUP: begin
               state   <= S_ACCESS;
               PENABLE <= 1'b1;
               to_cnt  <= '0;
            end
            S_ACCESS: begin
               if (PREADY) begin
                  PSEL    <= '0;
                  PENABLE <= 1'b0;
                  if (PSLVERR) begin
                     state <= S_ERR1;
                     HRESP <= HRESP_ERROR;
                  end else begin
                     state     <= S_DONE;
                     HREADYOUT <= 1'b1;
                     HRESP     <= HRESP_OKAY;
                     if (!write_q) HRDATA <= PRDATA;
                  end
               end else begin
                  to_cnt <= cnt_next;
                  if (timeout_hit) begin
                     PSEL    <= '0;
                     PENABLE <= 1'b0;
                     TOUT    <= 1'b1;
                     state   <= S_ERR1;
                     HRESP   <= HRESP_ERROR;
                  end
               end
            end
            S_ERR1: begin
               // Second half of the two-cycle AHB ERROR response.
               state     <= S_ERR2;
               HREADYOUT <= 1'b1;
               HRESP     <= HRESP_ERROR;
            end
            default: begin
               state     <= S_IDLE;
               HREADYOUT <= 1'b1;
               HRESP     <= HRESP_OKAY;
               PSEL      <= '0;
               PENABLE   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_bridge_multi.sv
// tb_apb_bridge_multi
//   Self-checking bench for apb_bridge_multi (NSLOTS=12, TIMEOUT=4).
//   An APB slave model answers with a programmable number of wait cycles;
//   each AHB transfer pushes its expected response, completion cycle,
//   timeout flag and HRDATA into exp_q, popped when HREADYOUT returns high.
module tb_apb_bridge_multi;
   import apb_bridge_pkg::*;

   localparam int NSLOTS   = 12;
   localparam int SLOT_LSB = 24;
   localparam int ADDR_W   = 32;
   localparam int TIMEOUT  = 4;

   logic              HCLK;
   logic              HRESETN;
   logic              HSEL;
   logic [31:0]       HADDR;
   logic              HWRITE;
   logic [1:0]        HTRANS;
   logic [31:0]       HWDATA;
   logic              HREADYIN;
   logic              HREADYOUT;
   logic              HRESP;
   logic [31:0]       HRDATA;
   logic [NSLOTS-1:0] PSEL;
   logic [ADDR_W-1:0] PADDR;
   logic              PWRITE;
   logic              PENABLE;
   logic [31:0]       PWDATA;
   logic [31:0]       PRDATA  = 32'h0;
   logic              PREADY  = 1'b0;
   logic              PSLVERR = 1'b0;
   logic              TOUT;
   state_t            dbg_state;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [40:0] exp_q[$];      // {resp, tout, done_cycle[6:0], hrdata}
   logic [31:0] model_hrdata = 32'h0;

   int          apb_waits = 0;
   logic        apb_err   = 1'b0;
   logic [31:0] apb_rdata = 32'h0;
   int          acc_cnt   = 0;

   apb_bridge_multi #(
      .NSLOTS   (NSLOTS),
      .SLOT_LSB (SLOT_LSB),
      .ADDR_W   (ADDR_W),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .HCLK      (HCLK),
      .HRESETN   (HRESETN),
      .HSEL      (HSEL),
      .HADDR     (HADDR),
      .HWRITE    (HWRITE),
      .HTRANS    (HTRANS),
      .HWDATA    (HWDATA),
      .HREADYIN  (HREADYIN),
      .HREADYOUT (HREADYOUT),
      .HRESP     (HRESP),
      .HRDATA    (HRDATA),
      .PSEL      (PSEL),
      .PADDR     (PADDR),
      .PWRITE    (PWRITE),
      .PENABLE   (PENABLE),
      .PWDATA    (PWDATA),
      .PRDATA    (PRDATA),
      .PREADY    (PREADY),
      .PSLVERR   (PSLVERR),
      .TOUT      (TOUT),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- APB slave model ----------------
   always @(negedge HCLK) begin
      if (PSEL != '0 && PENABLE) begin
         if (acc_cnt >= apb_waits) begin
            PREADY  = 1'b1;
            PSLVERR = apb_err;
            PRDATA  = apb_rdata;
         end else begin
            PREADY  = 1'b0;
            PSLVERR = 1'($urandom_range(0, 1));
            PRDATA  = $urandom();
         end
         acc_cnt++;
      end else begin
         PREADY  = 1'($urandom_range(0, 1));
         PSLVERR = 1'($urandom_range(0, 1));
         PRDATA  = $urandom();
         acc_cnt = 0;
      end
   end

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // ---------------- driver ----------------
   // Called at a negedge; drives the address phase, follows the transfer to
   // completion and leaves the bench at the negedge of the completion cycle.
   task automatic xfer(input string tag, input logic [31:0] addr, input logic wr,
                       input logic [31:0] wdata, input int waits, input logic err,
                       input logic [31:0] rdata);
      int          slot;
      logic        oor;
      logic        e_resp, e_tout;
      int          e_done, e_psel_end;
      logic [40:0] e;
      int          cyc, setup_cyc, err1_cyc, tout_cnt, psel_end;
      logic [31:0] psel_seen, paddr_seen, pwdata_seen;
      logic        pwrite_seen, psel_any;

      slot = int'(addr[SLOT_LSB +: 4]);
      oor  = (slot >= NSLOTS);
      e_psel_end = 3 + waits;
      if (oor) begin
         e_resp = 1'b1; e_tout = 1'b0; e_done = 3;
      end else if (waits >= TIMEOUT) begin
         e_resp = 1'b1; e_tout = 1'b1; e_done = 4 + TIMEOUT; e_psel_end = 2 + TIMEOUT;
      end else if (err) begin
         e_resp = 1'b1; e_tout = 1'b0; e_done = 5 + waits;
      end else begin
         e_resp = 1'b0; e_tout = 1'b0; e_done = 4 + waits;
         if (!wr) model_hrdata = rdata;
      end
      exp_q.push_back({e_resp, e_tout, 7'(e_done), model_hrdata});

      apb_waits = waits;
      apb_err   = err;
      apb_rdata = rdata;
      HSEL   = 1'b1;
      HADDR  = addr;
      HWRITE = wr;
      HTRANS = ($urandom_range(0, 1) == 1) ? HTRANS_SEQ : HTRANS_NONSEQ;
      HWDATA = $urandom();
      @(negedge HCLK);
      cyc    = 1;
      HSEL   = 1'b0;
      HTRANS = HTRANS_IDLE;
      HADDR  = $urandom();
      HWRITE = 1'($urandom_range(0, 1));
      HWDATA = wdata;
      check({tag, ".latch"}, 32'(dbg_state), 32'(S_LATCH));

      setup_cyc = 0; err1_cyc = 0; tout_cnt = 0; psel_end = 0; psel_any = 1'b0;
      psel_seen = 0; paddr_seen = 0; pwdata_seen = 0; pwrite_seen = 1'b0;
      while (!HREADYOUT && cyc < 64) begin
         if (PSEL != '0) begin
            psel_any = 1'b1;
            psel_end = cyc;
         end
         if (PSEL != '0 && !PENABLE && setup_cyc == 0) begin
            setup_cyc   = cyc;
            psel_seen   = 32'(PSEL);
            paddr_seen  = 32'(PADDR);
            pwdata_seen = PWDATA;
            pwrite_seen = PWRITE;
         end
         if (TOUT) tout_cnt++;
         if (HRESP) err1_cyc = cyc;
         @(negedge HCLK);
         cyc++;
         if (cyc == 2) HWDATA = $urandom();
      end
      if (TOUT) tout_cnt++;

      e = exp_q.pop_front();
      check({tag, ".done_cyc"}, 32'(cyc), 32'(e[38:32]));
      check({tag, ".hresp"}, 32'(HRESP), 32'(e[40]));
      check({tag, ".tout"}, 32'(tout_cnt), 32'(e[39]));
      check({tag, ".hrdata"}, HRDATA, e[31:0]);
      check({tag, ".psel_off"}, 32'(PSEL), 32'h0);
      if (oor) begin
         check({tag, ".no_psel"}, 32'(psel_any), 32'h0);
      end else begin
         check({tag, ".setup_cyc"}, 32'(setup_cyc), 32'd2);
         check({tag, ".psel"}, psel_seen, 32'd1 << slot);
         check({tag, ".paddr"}, paddr_seen, addr);
         check({tag, ".pwrite"}, 32'(pwrite_seen), 32'(wr));
         check({tag, ".psel_end"}, 32'(psel_end), 32'(e_psel_end));
         if (wr) check({tag, ".pwdata"}, pwdata_seen, wdata);
      end
      if (e[40]) check({tag, ".err1"}, 32'(err1_cyc), 32'(cyc - 1));
   endtask

   task automatic idle_cycles(input int n);
      HSEL   = 1'b0;
      HTRANS = HTRANS_IDLE;
      repeat (n) @(negedge HCLK);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, ".state"}, 32'(dbg_state), 32'(S_IDLE));
      check({tag, ".hreadyout"}, 32'(HREADYOUT), 32'h1);
      check({tag, ".hresp"}, 32'(HRESP), 32'h0);
      check({tag, ".hrdata"}, HRDATA, 32'h0);
      check({tag, ".psel"}, 32'(PSEL), 32'h0);
      check({tag, ".penable"}, 32'(PENABLE), 32'h0);
      check({tag, ".pwrite"}, 32'(PWRITE), 32'h0);
      check({tag, ".paddr"}, 32'(PADDR), 32'h0);
      check({tag, ".pwdata"}, PWDATA, 32'h0);
      check({tag, ".tout"}, 32'(TOUT), 32'h0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] a;
      int          w;
      int          k;
      HRESETN  = 1'b0;
      HSEL     = 1'b0;
      HADDR    = 32'h0;
      HWRITE   = 1'b0;
      HTRANS   = HTRANS_IDLE;
      HWDATA   = 32'h0;
      HREADYIN = 1'b1;
      repeat (3) @(negedge HCLK);
      check_reset_values("reset");
      HRESETN = 1'b1;
      @(negedge HCLK);

      // IDLE/BUSY, unselected and HREADYIN=0 cycles must not start anything.
      HSEL = 1'b1; HTRANS = HTRANS_BUSY; HADDR = 32'h0500_0000;
      @(negedge HCLK);
      check("busy.state", 32'(dbg_state), 32'(S_IDLE));
      check("busy.hready", 32'(HREADYOUT), 32'h1);
      HSEL = 1'b0; HTRANS = HTRANS_NONSEQ;
      @(negedge HCLK);
      check("unsel.state", 32'(dbg_state), 32'(S_IDLE));
      HSEL = 1'b1; HREADYIN = 1'b0;
      @(negedge HCLK);
      check("nordy.state", 32'(dbg_state), 32'(S_IDLE));
      check("nordy.psel", 32'(PSEL), 32'h0);
      HREADYIN = 1'b1;
      idle_cycles(1);

      xfer("wr_slot5", 32'h0500_0010, 1'b1, 32'hCAFE_F00D, 0, 1'b0, 32'h0);
      idle_cycles(2);
      xfer("rd_wait3", 32'h0200_0004, 1'b0, 32'h0, 3, 1'b0, 32'h1234_5678);
      idle_cycles(1);
      xfer("rd_slverr", 32'h0100_0008, 1'b0, 32'h0, 1, 1'b1, 32'hDEAD_BEEF);
      idle_cycles(1);
      xfer("rd_timeout", 32'h0400_0000, 1'b0, 32'h0, TIMEOUT, 1'b0, 32'h5555_AAAA);
      idle_cycles(1);
      xfer("rd_to_edge", 32'h0400_0004, 1'b0, 32'h0, TIMEOUT - 1, 1'b0, 32'hA5A5_5A5A);
      idle_cycles(1);
      xfer("wr_slot13", 32'h0D00_0000, 1'b1, 32'h1111_2222, 0, 1'b0, 32'h0);
      xfer("b2b_err2", 32'h0B00_000C, 1'b0, 32'h0, 0, 1'b0, 32'h0BAD_F00D);
      xfer("b2b_done", 32'h0000_0100, 1'b1, 32'h7777_8888, 2, 1'b0, 32'h0);
      idle_cycles(1);

      for (int i = 0; i < 24; i++) begin
         a = $urandom();
         a[27:24] = 4'($urandom_range(0, 15));
         w = $urandom_range(0, 5);
         xfer("rand", a, 1'($urandom_range(0, 1)), $urandom(), w,
              ($urandom_range(0, 3) == 0), $urandom());
         if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
      end
      idle_cycles(1);

      // Reset in the middle of an ACCESS phase.
      apb_waits = 100;
      HSEL = 1'b1; HADDR = 32'h0300_0040; HWRITE = 1'b0; HTRANS = HTRANS_NONSEQ;
      @(negedge HCLK);
      HSEL = 1'b0; HTRANS = HTRANS_IDLE;
      k = 0;
      while (dbg_state != S_ACCESS && k < 10) begin
         @(negedge HCLK);
         k++;
      end
      check("rst.reach_access", 32'(dbg_state), 32'(S_ACCESS));
      #2 HRESETN = 1'b0;
      #1 check_reset_values("rst_mid");
      model_hrdata = 32'h0;
      @(negedge HCLK);
      HRESETN = 1'b1;
      @(negedge HCLK);
      xfer("post_rst", 32'h0300_0044, 1'b0, 32'h0, 1, 1'b0, 32'h600D_CAFE);
      idle_cycles(2);

      check("exp_q.empty", 32'(exp_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/apb_bridge_multi.md
APB_BRIDGE_MULTI -- requirements
Module: apb_bridge_multi

Interface
REQ-001 SHALL have parameter NSLOTS, default 16, number of APB slave select lines (1..16).
REQ-002 SHALL have parameter SLOT_LSB, default 24, lowest HADDR bit of the slot field (field width clog2(NSLOTS), minimum 1).
REQ-003 SHALL have parameter ADDR_W, default 32, PADDR width (1..32).
REQ-004 SHALL have parameter TIMEOUT, default 256, ACCESS cycles with PREADY=0 before abort; 0 disables the timeout.
REQ-005 SHALL have port HCLK  in  1  single clock for all logic.
REQ-006 SHALL have port HRESETN  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports HSEL in 1, HADDR in 32, HWRITE in 1, HTRANS in 2, HWDATA in 32, HREADYIN in 1: AHB-Lite slave inputs.
REQ-008 SHALL have ports HREADYOUT out 1, HRESP out 1, HRDATA out 32: AHB-Lite slave outputs.
REQ-009 SHALL have ports PSEL out NSLOTS, PADDR out ADDR_W, PWRITE out 1, PENABLE out 1, PWDATA out 32: APB3 master outputs.
REQ-010 SHALL have ports PRDATA in 32, PREADY in 1, PSLVERR in 1: APB3 master inputs.
REQ-011 SHALL have port TOUT  out  1  one-cycle pulse when a transfer is aborted by timeout.

Function
REQ-012 SHALL accept a transfer on a rising HCLK edge when HSEL=1, HREADYIN=1, HTRANS[1]=1 and state is IDLE, DONE or ERR2; at that edge it SHALL latch HADDR, HWRITE and the decoded slot.
REQ-013 SHALL answer IDLE/BUSY transfers and unselected cycles with HREADYOUT=1, HRESP=0 and no APB activity.
REQ-014 SHALL implement states IDLE, LATCH, SETUP, ACCESS, DONE, ERR1 and ERR2.
REQ-015 In LATCH (the AHB data phase), SHALL drive HREADYOUT=0 and register HWDATA into PWDATA; next state SHALL be SETUP, or ERR1 if the slot index is >= NSLOTS.
REQ-016 In SETUP, SHALL drive one-hot PSEL[slot]=1, PENABLE=0, PADDR=HADDR[ADDR_W-1:0] and PWRITE; next state SHALL be ACCESS.
REQ-017 In ACCESS, SHALL hold PSEL, PADDR, PWRITE and PWDATA and drive PENABLE=1.
REQ-018 In ACCESS with PREADY=1 and PSLVERR=0, SHALL register PRDATA into HRDATA (reads only) and go to DONE.
REQ-019 In ACCESS with PREADY=1 and PSLVERR=1, SHALL go to ERR1.
REQ-020 In DONE, SHALL drive HREADYOUT=1 and HRESP=0; next state SHALL be LATCH if a transfer is accepted (REQ-012), else IDLE.
REQ-021 In ERR1, SHALL drive HREADYOUT=0 and HRESP=1. In ERR2, SHALL drive HREADYOUT=1 and HRESP=1, then go to LATCH or IDLE as in REQ-020.
REQ-022 SHALL drive PSEL=0 and PENABLE=0 in every state except SETUP and ACCESS.
REQ-023 Zero-wait latency: acceptance at edge 0 SHALL give LATCH in cycle 1, SETUP in cycle 2, ACCESS in cycle 3 and DONE in cycle 4; each APB wait cycle SHALL add one cycle.
REQ-024 Timeout: a counter of width clog2(TIMEOUT+1) SHALL clear on entry to ACCESS and increment on each ACCESS cycle with PREADY=0.
REQ-025 When the timeout counter equals TIMEOUT (TIMEOUT>0), SHALL deassert PSEL and PENABLE, pulse TOUT for one cycle and go to ERR1.
REQ-026 PREADY=1 in the same cycle the timeout count is reached SHALL complete the transfer normally, with no TOUT pulse.
REQ-027 HRDATA SHALL hold its last value and SHALL NOT update on writes, errors or timeouts.
REQ-028 With NSLOTS=1, the slot field SHALL be ignored and no decode error SHALL occur.

Reset
REQ-029 On HRESETN=0, asynchronously: state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, TOUT=0, timeout counter=0.
REQ-030 Reset asserted mid-transfer SHALL abandon the transfer with no completion; operation SHALL resume from IDLE on the first edge after release.

Structure
REQ-031 Package apb_bridge_pkg SHALL hold the state encoding, the HTRANS codes (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3) and the HRESP codes (OKAY=0, ERROR=1).
REQ-032 Slot decode SHALL be a sub-module, apb_bridge_decode (slot index -> one-hot NSLOTS vector plus out-of-range flag).

Verification
REQ-033 Write 0x05000010 <- 0xCAFEF00D with PREADY=1 -> PSEL=0x0020, PADDR=0x05000010, PWDATA=0xCAFEF00D; SETUP in cycle 2; HREADYOUT=1, HRESP=0 in cycle 4.
REQ-034 Read 0x02000004 with PREADY low for 3 ACCESS cycles and PRDATA=0x12345678 -> HRDATA=0x12345678, HREADYOUT=1 in cycle 7.
REQ-035 Read with PSLVERR=1 on the completing cycle -> ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1); HRDATA unchanged.
REQ-036 TIMEOUT=4 with PREADY held 0 -> PSEL=0 after 4 ACCESS cycles, TOUT high for 1 cycle, two-cycle ERROR response.
REQ-037 NSLOTS=12, access to slot 13 -> no PSEL asserted and a two-cycle ERROR response; back-to-back NONSEQ accepted in DONE starts LATCH in the next cycle.
REQ-038 HRESETN=0 during ACCESS -> all outputs at reset values immediately; the next transfer completes normally.
